// File: rtl/bp_cce_hybrid_req_router_pkg.sv
// ---------------------------------------------------------------------------
// bp_cce_hybrid_req_router_pkg
//
// Shared types and helpers for the hybrid CCE request router:
//   - BedRock LCE request message types seen by the router
//   - request header struct carried on the burst ports
//   - route class and FSM state enums
//   - classification and expected-beat helper functions
// ---------------------------------------------------------------------------
package bp_cce_hybrid_req_router_pkg;

   localparam int paddr_width_gp     = 40;
   localparam int lce_id_width_gp    = 4;
   // Widest request is 128B; with beats of at least 64 bits that is 16 beats
   localparam int exp_beats_width_gp = 5;

   typedef enum logic [3:0] {
      e_bedrock_req_rd_miss = 4'd0,
      e_bedrock_req_wr_miss = 4'd1,
      e_bedrock_req_uc_rd   = 4'd2,
      e_bedrock_req_uc_wr   = 4'd3,
      e_bedrock_req_uc_amo  = 4'd4
   } bp_bedrock_req_type_e;

   typedef enum logic {
      e_req_route_uc  = 1'b0,
      e_req_route_coh = 1'b1
   } bp_cce_hybrid_req_route_e;

   typedef enum logic [1:0] {
      e_ready,
      e_data_uc,
      e_data_coh
   } bp_cce_hybrid_req_state_e;

   // msg_size encodes the request size as 2^msg_size bytes
   typedef struct packed {
      logic [3:0]                 msg_type;
      logic [2:0]                 msg_size;
      logic [lce_id_width_gp-1:0] lce_id;
      logic [paddr_width_gp-1:0]  addr;
   } bp_cce_hybrid_req_hdr_s;

   function automatic logic bp_cce_hybrid_req_is_known(input logic [3:0] msg_type);
      return (msg_type == e_bedrock_req_rd_miss) || (msg_type == e_bedrock_req_wr_miss)
          || (msg_type == e_bedrock_req_uc_rd)   || (msg_type == e_bedrock_req_uc_wr)
          || (msg_type == e_bedrock_req_uc_amo);
   endfunction

   // Only read/write misses go coherent; unknown types fall to the uncached pipe
   function automatic logic bp_cce_hybrid_req_is_uc(input logic [3:0] msg_type, input logic mode);
      return mode || !((msg_type == e_bedrock_req_rd_miss) || (msg_type == e_bedrock_req_wr_miss));
   endfunction

   // Beats of beat_width bits needed to carry 2^msg_size bytes, at least one
   function automatic logic [exp_beats_width_gp-1:0] bp_cce_hybrid_exp_beats
      (input logic [2:0] msg_size, input int beat_width);
      int bits;
      int beats;
      bits  = (1 << msg_size) * 8;
      beats = bits / beat_width;
      if (beats < 1) beats = 1;
      return beats[exp_beats_width_gp-1:0];
   endfunction

endpackage

// File: rtl/bp_cce_hybrid_req_router_hdr_buffer.sv
// ---------------------------------------------------------------------------
// bp_cce_hybrid_hdr_buffer
//
// One-entry header register with valid/ready handshake on both sides.
// Pass-through ready: a new header can be loaded in the same cycle the
// held one is taken downstream. If free and load coincide, the load wins.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   load_i              write hdr_i/has_data_i this cycle (caller checks ready_o)
//   hdr_i, has_data_i   incoming header and has-data flag
//   ready_o             entry empty or being freed this cycle
//   v_o, hdr_o,
//   has_data_o          held entry (zero when empty)
//   ready_i             downstream ready
// ---------------------------------------------------------------------------
module bp_cce_hybrid_hdr_buffer
   import bp_cce_hybrid_req_router_pkg::*;
   (
      input  logic                   clk_i,
      input  logic                   reset_i,
      input  logic                   load_i,
      input  bp_cce_hybrid_req_hdr_s hdr_i,
      input  logic                   has_data_i,
      output logic                   ready_o,
      output logic                   v_o,
      output bp_cce_hybrid_req_hdr_s hdr_o,
      output logic                   has_data_o,
      input  logic                   ready_i
   );

   logic                   v_q, v_d;
   logic                   has_data_q, has_data_d;
   bp_cce_hybrid_req_hdr_s hdr_q, hdr_d;

   assign ready_o    = ~v_q | ready_i;
   assign v_o        = v_q;
   assign hdr_o      = hdr_q;
   assign has_data_o = has_data_q;

   // Entry contents are cleared on free so an empty buffer presents zeros
   always_comb begin
      v_d        = v_q;
      hdr_d      = hdr_q;
      has_data_d = has_data_q;
      if (load_i) begin
         v_d        = 1'b1;
         hdr_d      = hdr_i;
         has_data_d = has_data_i;
      end else if (v_q && ready_i) begin
         v_d        = 1'b0;
         hdr_d      = '0;
         has_data_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q        <= 1'b0;
         hdr_q      <= '0;
         has_data_q <= 1'b0;
      end else begin
         v_q        <= v_d;
         hdr_q      <= hdr_d;
         has_data_q <= has_data_d;
      end
   end

endmodule

// File: rtl/bp_cce_hybrid_req_router.sv
// ---------------------------------------------------------------------------
// bp_cce_hybrid_req_router
//
// Steers unblocked BedRock-burst LCE requests to the uncached (uc) or
// coherent (coh) pipe. Headers are registered in a one-entry buffer per
// output; data beats then pass combinationally to the chosen port, locked
// until the last beat. The beat count is checked against msg_size.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   cce_mode_i              1 = uncached-only mode
//   lce_req_*               input burst (header/has_data/data/last, v/ready)
//   uc_*, coh_*             output burst ports, same shape as input
//   beat_err_o              sticky: bad msg_type or beat-count mismatch
//   idle_o                  FSM ready and both header buffers empty
//   stats_*_o               request/stall counters, only with
//                           BP_CCE_HYBRID_REQ_ROUTER_STATS_EN defined
// ---------------------------------------------------------------------------
module bp_cce_hybrid_req_router
   import bp_cce_hybrid_req_router_pkg::*;
   #(
      parameter int lce_data_width_p  = 64,
      parameter int cce_block_width_p = 512
   )
   (
      input  logic                        clk_i,
      input  logic                        reset_i,
      input  logic                        cce_mode_i,

      input  bp_cce_hybrid_req_hdr_s      lce_req_header_i,
      input  logic                        lce_req_header_v_i,
      output logic                        lce_req_header_ready_and_o,
      input  logic                        lce_req_has_data_i,
      input  logic [lce_data_width_p-1:0] lce_req_data_i,
      input  logic                        lce_req_data_v_i,
      output logic                        lce_req_data_ready_and_o,
      input  logic                        lce_req_last_i,

      output bp_cce_hybrid_req_hdr_s      uc_header_o,
      output logic                        uc_header_v_o,
      input  logic                        uc_header_ready_and_i,
      output logic                        uc_has_data_o,
      output logic [lce_data_width_p-1:0] uc_data_o,
      output logic                        uc_data_v_o,
      input  logic                        uc_data_ready_and_i,
      output logic                        uc_last_o,

      output bp_cce_hybrid_req_hdr_s      coh_header_o,
      output logic                        coh_header_v_o,
      input  logic                        coh_header_ready_and_i,
      output logic                        coh_has_data_o,
      output logic [lce_data_width_p-1:0] coh_data_o,
      output logic                        coh_data_v_o,
      input  logic                        coh_data_ready_and_i,
      output logic                        coh_last_o,

      output logic                        beat_err_o,
`ifdef BP_CCE_HYBRID_REQ_ROUTER_STATS_EN
      output logic [31:0]                 stats_uc_o,
      output logic [31:0]                 stats_coh_o,
      output logic [31:0]                 stats_stall_o,
`endif
      output logic                        idle_o
   );

   localparam int max_beats_lp      = cce_block_width_p / lce_data_width_p;
   localparam int beat_cnt_width_lp = $clog2(max_beats_lp + 1);
   localparam int cmp_width_lp      = ((beat_cnt_width_lp > exp_beats_width_gp)
                                       ? beat_cnt_width_lp : exp_beats_width_gp) + 1;

   bp_cce_hybrid_req_state_e         state_q, state_d;
   logic [beat_cnt_width_lp-1:0]     beat_cnt_q, beat_cnt_d;
   logic [exp_beats_width_gp-1:0]    exp_beats_q, exp_beats_d;
   logic                             beat_err_q, beat_err_d;

   bp_cce_hybrid_req_route_e route;
   logic                     bad_type;
   logic                     hdr_ready, hdr_accept, data_ready, beat_hs;
   logic                     uc_dv, coh_dv;

   logic                     uc_buf_ready, uc_buf_v, uc_buf_has_data;
   logic                     coh_buf_ready, coh_buf_v, coh_buf_has_data;
   bp_cce_hybrid_req_hdr_s   uc_buf_hdr, coh_buf_hdr;

   assign route    = bp_cce_hybrid_req_is_uc(lce_req_header_i.msg_type, cce_mode_i)
                     ? e_req_route_uc : e_req_route_coh;
   assign bad_type = ~bp_cce_hybrid_req_is_known(lce_req_header_i.msg_type);

   assign hdr_accept = lce_req_header_v_i & hdr_ready;
   assign beat_hs    = lce_req_data_v_i & data_ready;

   bp_cce_hybrid_hdr_buffer uc_buf (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (hdr_accept && (route == e_req_route_uc)),
      .hdr_i      (lce_req_header_i),
      .has_data_i (lce_req_has_data_i),
      .ready_o    (uc_buf_ready),
      .v_o        (uc_buf_v),
      .hdr_o      (uc_buf_hdr),
      .has_data_o (uc_buf_has_data),
      .ready_i    (uc_header_ready_and_i)
   );

   bp_cce_hybrid_hdr_buffer coh_buf (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (hdr_accept && (route == e_req_route_coh)),
      .hdr_i      (lce_req_header_i),
      .has_data_i (lce_req_has_data_i),
      .ready_o    (coh_buf_ready),
      .v_o        (coh_buf_v),
      .hdr_o      (coh_buf_hdr),
      .has_data_o (coh_buf_has_data),
      .ready_i    (coh_header_ready_and_i)
   );

   // Next-state and handshake logic. While a burst is locked to a port, its
   // data is held back until that port's buffered header has left, so a beat
   // can never overtake its header. The buffer only ever holds this burst's
   // header because new headers are refused during a burst.
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      exp_beats_d = exp_beats_q;
      beat_err_d  = beat_err_q;
      hdr_ready   = 1'b0;
      data_ready  = 1'b0;
      uc_dv       = 1'b0;
      coh_dv      = 1'b0;

      case (state_q)
         e_ready: begin
            hdr_ready = (route == e_req_route_uc) ? uc_buf_ready : coh_buf_ready;
            if (lce_req_header_v_i && hdr_ready && !reset_i) begin
               if (bad_type) beat_err_d = 1'b1;
               if (lce_req_has_data_i) begin
                  state_d     = (route == e_req_route_uc) ? e_data_uc : e_data_coh;
                  beat_cnt_d  = '0;
                  exp_beats_d = bp_cce_hybrid_exp_beats(lce_req_header_i.msg_size,
                                                        lce_data_width_p);
               end
            end
         end
         e_data_uc: begin
            uc_dv      = lce_req_data_v_i & ~uc_buf_v;
            data_ready = uc_data_ready_and_i & ~uc_buf_v;
         end
         e_data_coh: begin
            coh_dv     = lce_req_data_v_i & ~coh_buf_v;
            data_ready = coh_data_ready_and_i & ~coh_buf_v;
         end
         default: state_d = e_ready;
      endcase

      if (reset_i) begin
         hdr_ready  = 1'b0;
         data_ready = 1'b0;
         uc_dv      = 1'b0;
         coh_dv     = 1'b0;
      end

      // Beat counting saturates so an overlong burst still flags a mismatch
      if (lce_req_data_v_i && data_ready) begin
         if (beat_cnt_q != {beat_cnt_width_lp{1'b1}})
            beat_cnt_d = beat_cnt_q + beat_cnt_width_lp'(1);
         if (lce_req_last_i) begin
            state_d = e_ready;
            if ((cmp_width_lp'(beat_cnt_q) + cmp_width_lp'(1)) != cmp_width_lp'(exp_beats_q))
               beat_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= e_ready;
         beat_cnt_q  <= '0;
         exp_beats_q <= '0;
         beat_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         exp_beats_q <= exp_beats_d;
         beat_err_q  <= beat_err_d;
      end
   end

   assign lce_req_header_ready_and_o = hdr_ready;
   assign lce_req_data_ready_and_o   = data_ready;

   assign uc_header_v_o  = uc_buf_v & ~reset_i;
   assign uc_header_o    = uc_header_v_o ? uc_buf_hdr : '0;
   assign uc_has_data_o  = uc_header_v_o & uc_buf_has_data;
   assign uc_data_v_o    = uc_dv;
   assign uc_data_o      = uc_dv ? lce_req_data_i : '0;
   assign uc_last_o      = uc_dv & lce_req_last_i;

   assign coh_header_v_o = coh_buf_v & ~reset_i;
   assign coh_header_o   = coh_header_v_o ? coh_buf_hdr : '0;
   assign coh_has_data_o = coh_header_v_o & coh_buf_has_data;
   assign coh_data_v_o   = coh_dv;
   assign coh_data_o     = coh_dv ? lce_req_data_i : '0;
   assign coh_last_o     = coh_dv & lce_req_last_i;

   assign beat_err_o = beat_err_q;
   assign idle_o     = (state_q == e_ready) & ~uc_buf_v & ~coh_buf_v;

`ifdef BP_CCE_HYBRID_REQ_ROUTER_STATS_EN
   logic [31:0] uc_req_cnt_q, uc_req_cnt_d;
   logic [31:0] coh_req_cnt_q, coh_req_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating counters of accepted requests per route and header stalls
   always_comb begin
      uc_req_cnt_d  = uc_req_cnt_q;
      coh_req_cnt_d = coh_req_cnt_q;
      stall_cnt_d   = stall_cnt_q;
      if (hdr_accept && (route == e_req_route_uc) && (uc_req_cnt_q != '1))
         uc_req_cnt_d = uc_req_cnt_q + 32'd1;
      if (hdr_accept && (route == e_req_route_coh) && (coh_req_cnt_q != '1))
         coh_req_cnt_d = coh_req_cnt_q + 32'd1;
      if (lce_req_header_v_i && !hdr_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         uc_req_cnt_q  <= '0;
         coh_req_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         uc_req_cnt_q  <= uc_req_cnt_d;
         coh_req_cnt_q <= coh_req_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign stats_uc_o    = uc_req_cnt_q;
   assign stats_coh_o   = coh_req_cnt_q;
   assign stats_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_req_router.sv
// ---------------------------------------------------------------------------
// tb_bp_cce_hybrid_req_router
//
// Directed bench for the hybrid CCE request router. A reference model of
// what each output port must deliver (header/beat queues per route plus the
// sticky error flag) is kept alongside the directed sequences.
// ---------------------------------------------------------------------------
module tb_bp_cce_hybrid_req_router;
   import bp_cce_hybrid_req_router_pkg::*;

   localparam int HW = $bits(bp_cce_hybrid_req_hdr_s);

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic cceMode = 1'b0;

   bp_cce_hybrid_req_hdr_s headerIn = '0;
   logic        headerValid = 1'b0;
   logic        headerReady;
   logic        hasData = 1'b0;
   logic [63:0] dataIn = '0;
   logic        dataValid = 1'b0;
   logic        dataReady;
   logic        lastIn = 1'b0;

   bp_cce_hybrid_req_hdr_s ucHeader, cohHeader;
   logic        ucHeaderValid, cohHeaderValid;
   logic        ucHeaderReady = 1'b1, cohHeaderReady = 1'b1;
   logic        ucHasData, cohHasData;
   logic [63:0] ucData, cohData;
   logic        ucDataValid, cohDataValid;
   logic        ucDataReady = 1'b1, cohDataReady = 1'b1;
   logic        ucLast, cohLast;
   logic        beatErr, idle;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [HW:0] ucHdrQ[$], cohHdrQ[$];
   logic [64:0] ucBeatQ[$], cohBeatQ[$];
   logic        modelErr = 1'b0;
   logic        burstUc = 1'b0;
   logic        routeUc;
   logic [HW:0] popHdr;
   logic [64:0] popBeat;
   int          burstCnt = 0;
   int          burstExp = 0;

   always #5 clock = ~clock;

   bp_cce_hybrid_req_router #(.lce_data_width_p(64), .cce_block_width_p(512)) dut (
      .clk_i                      (clock),
      .reset_i                    (reset),
      .cce_mode_i                 (cceMode),
      .lce_req_header_i           (headerIn),
      .lce_req_header_v_i         (headerValid),
      .lce_req_header_ready_and_o (headerReady),
      .lce_req_has_data_i         (hasData),
      .lce_req_data_i             (dataIn),
      .lce_req_data_v_i           (dataValid),
      .lce_req_data_ready_and_o   (dataReady),
      .lce_req_last_i             (lastIn),
      .uc_header_o                (ucHeader),
      .uc_header_v_o              (ucHeaderValid),
      .uc_header_ready_and_i      (ucHeaderReady),
      .uc_has_data_o              (ucHasData),
      .uc_data_o                  (ucData),
      .uc_data_v_o                (ucDataValid),
      .uc_data_ready_and_i        (ucDataReady),
      .uc_last_o                  (ucLast),
      .coh_header_o               (cohHeader),
      .coh_header_v_o             (cohHeaderValid),
      .coh_header_ready_and_i     (cohHeaderReady),
      .coh_has_data_o             (cohHasData),
      .coh_data_o                 (cohData),
      .coh_data_v_o               (cohDataValid),
      .coh_data_ready_and_i       (cohDataReady),
      .coh_last_o                 (cohLast),
      .beat_err_o                 (beatErr),
      .idle_o                     (idle)
   );

   // A request of 2^size bytes in 64-bit beats, never fewer than one
   function automatic int modelExpBeats(input logic [2:0] size);
      int b;
      b = ((1 << size) * 8) / 64;
      return (b < 1) ? 1 : b;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic reportEmpty(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: output handshake with no expected item", name);
   endtask

   // Compare process: checks outputs against the model, then folds this
   // cycle's input handshakes into the model so they apply from next cycle
   always @(negedge clock) begin
      if (reset) begin
         ucHdrQ.delete();
         cohHdrQ.delete();
         ucBeatQ.delete();
         cohBeatQ.delete();
         modelErr = 1'b0;
         burstCnt = 0;
      end else begin
         checkOutput("beat_err", 64'(beatErr), 64'(modelErr));
         if (!ucHeaderValid)  checkOutput("uc_hdr_zero", 64'({ucHasData, ucHeader}), 64'd0);
         if (!cohHeaderValid) checkOutput("coh_hdr_zero", 64'({cohHasData, cohHeader}), 64'd0);
         if (!ucDataValid)    checkOutput("uc_data_zero", ucData | 64'(ucLast), 64'd0);
         if (!cohDataValid)   checkOutput("coh_data_zero", cohData | 64'(cohLast), 64'd0);
         if (ucDataValid)     checkOutput("uc_data_after_hdr", 64'(ucHeaderValid), 64'd0);
         if (cohDataValid)    checkOutput("coh_data_after_hdr", 64'(cohHeaderValid), 64'd0);

         if (headerValid && headerReady) begin
            routeUc = cceMode || !(headerIn.msg_type inside {4'd0, 4'd1});
            if (routeUc) ucHdrQ.push_back({hasData, headerIn});
            else         cohHdrQ.push_back({hasData, headerIn});
            if (headerIn.msg_type > 4'd4) modelErr = 1'b1;
            if (hasData) begin
               burstUc  = routeUc;
               burstCnt = 0;
               burstExp = modelExpBeats(headerIn.msg_size);
            end
         end
         if (dataValid && dataReady) begin
            if (burstUc) ucBeatQ.push_back({lastIn, dataIn});
            else         cohBeatQ.push_back({lastIn, dataIn});
            burstCnt++;
            if (lastIn && (burstCnt != burstExp)) modelErr = 1'b1;
         end

         if (ucHeaderValid && ucHeaderReady) begin
            if (ucHdrQ.size() == 0) reportEmpty("uc_hdr");
            else begin
               popHdr = ucHdrQ.pop_front();
               checkOutput("uc_hdr", 64'({ucHasData, ucHeader}), 64'(popHdr));
            end
         end
         if (cohHeaderValid && cohHeaderReady) begin
            if (cohHdrQ.size() == 0) reportEmpty("coh_hdr");
            else begin
               popHdr = cohHdrQ.pop_front();
               checkOutput("coh_hdr", 64'({cohHasData, cohHeader}), 64'(popHdr));
            end
         end
         if (ucDataValid && ucDataReady) begin
            if (ucBeatQ.size() == 0) reportEmpty("uc_beat");
            else begin
               popBeat = ucBeatQ.pop_front();
               checkOutput("uc_beat_data", ucData, popBeat[63:0]);
               checkOutput("uc_beat_last", 64'(ucLast), 64'(popBeat[64]));
            end
         end
         if (cohDataValid && cohDataReady) begin
            if (cohBeatQ.size() == 0) reportEmpty("coh_beat");
            else begin
               popBeat = cohBeatQ.pop_front();
               checkOutput("coh_beat_data", cohData, popBeat[63:0]);
               checkOutput("coh_beat_last", 64'(cohLast), 64'(popBeat[64]));
            end
         end
      end
   end

   // Present one header and hold it until accepted, within a cycle budget
   task automatic applyStimulus(input logic [3:0] msgType, input logic [2:0] size,
                                input logic [39:0] addr, input logic withData);
      bit accepted = 0;
      headerIn.msg_type = msgType;
      headerIn.msg_size = size;
      headerIn.lce_id   = 4'h3;
      headerIn.addr     = addr;
      hasData           = withData;
      headerValid       = 1'b1;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clock);
         accepted = headerReady;
         @(posedge clock);
         #1;
      end
      headerValid = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL hdr_accept_timeout: addr %0h never accepted", addr);
      end
   endtask

   // Send n beats base, base+1, ...; last flagged on the final beat if withLast
   task automatic sendBeats(input int n, input logic [63:0] base, input logic withLast);
      for (int b = 0; b < n; b++) begin
         bit done = 0;
         dataIn    = base + 64'(b);
         lastIn    = withLast && (b == n - 1);
         dataValid = 1'b1;
         for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            done = dataReady;
            @(posedge clock);
            #1;
         end
         if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: beat %0d never accepted", b);
         end
      end
      dataValid = 1'b0;
      lastIn    = 1'b0;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_idle", 64'(idle), 64'd1);
      checkOutput("reset_valids", 64'({ucHeaderValid, cohHeaderValid, ucDataValid, cohDataValid}), 64'd0);
      checkOutput("reset_err", 64'(beatErr), 64'd0);

      // Uncached read, no data
      applyStimulus(4'd2, 3'd3, 40'h100, 1'b0);
      @(negedge clock);
      checkOutput("ucrd_uc_valid", 64'(ucHeaderValid), 64'd1);
      checkOutput("ucrd_coh_valid", 64'(cohHeaderValid), 64'd0);
      checkOutput("ucrd_hdr_ready", 64'(headerReady), 64'd1);
      @(posedge clock);
      #1;

      // Write miss with a full 64B block: 8 beats on the coherent port
      applyStimulus(4'd1, 3'd6, 40'h200, 1'b1);
      sendBeats(8, 64'hA0, 1'b1);
      @(negedge clock);
      checkOutput("wrmiss_idle", 64'(idle), 64'd1);
      checkOutput("wrmiss_err", 64'(beatErr), 64'd0);
      @(posedge clock);
      #1;

      // Single-byte uncached write: one beat expected, one sent
      applyStimulus(4'd3, 3'd0, 40'h300, 1'b1);
      sendBeats(1, 64'hB0, 1'b1);
      @(negedge clock);
      checkOutput("ucwr1_err", 64'(beatErr), 64'd0);
      @(posedge clock);
      #1;

      // 8B uncached write carrying two beats: count mismatch
      applyStimulus(4'd3, 3'd3, 40'h308, 1'b1);
      sendBeats(2, 64'hC0, 1'b1);
      @(negedge clock);
      checkOutput("ucwr2_err", 64'(beatErr), 64'd1);
      checkOutput("ucwr2_idle", 64'(idle), 64'd1);
      @(posedge clock);
      #1;
      pulseReset();

      // Unknown message type goes uncached and raises the error flag
      applyStimulus(4'hF, 3'd3, 40'h400, 1'b0);
      @(negedge clock);
      checkOutput("badtype_uc_valid", 64'(ucHeaderValid), 64'd1);
      checkOutput("badtype_err", 64'(beatErr), 64'd1);
      @(posedge clock);
      #1;

      // Back-to-back read misses with the coherent header port stalled
      cohHeaderReady = 1'b0;
      applyStimulus(4'd0, 3'd6, 40'h500, 1'b0);
      headerIn.addr = 40'h540;
      headerValid   = 1'b1;
      @(negedge clock);
      checkOutput("stall_ready", 64'(headerReady), 64'd0);
      checkOutput("stall_coh_valid", 64'(cohHeaderValid), 64'd1);
      @(posedge clock);
      #1;
      cohHeaderReady = 1'b1;
      applyStimulus(4'd0, 3'd6, 40'h540, 1'b0);
      @(negedge clock);
      checkOutput("stall_second_out", 64'(cohHeader.addr), 64'h540);
      @(posedge clock);
      #1;

      // Uncached-only mode sends a read miss to the uncached port
      cceMode = 1'b1;
      applyStimulus(4'd0, 3'd6, 40'h600, 1'b0);
      @(negedge clock);
      checkOutput("mode_uc_valid", 64'(ucHeaderValid), 64'd1);
      checkOutput("mode_coh_valid", 64'(cohHeaderValid), 64'd0);
      @(posedge clock);
      #1;
      cceMode = 1'b0;

      // Reset in the middle of an 8-beat burst
      applyStimulus(4'd1, 3'd6, 40'h700, 1'b1);
      sendBeats(3, 64'hD0, 1'b0);
      reset     = 1'b1;
      dataValid = 1'b1;
      @(negedge clock);
      checkOutput("inreset_valids", 64'({ucHeaderValid, cohHeaderValid, ucDataValid, cohDataValid}), 64'd0);
      checkOutput("inreset_ready", 64'({headerReady, dataReady}), 64'd0);
      @(posedge clock);
      #1;
      reset     = 1'b0;
      dataValid = 1'b0;
      @(negedge clock);
      checkOutput("postreset_idle", 64'(idle), 64'd1);
      checkOutput("postreset_err", 64'(beatErr), 64'd0);
      checkOutput("postreset_valids", 64'({ucHeaderValid, cohHeaderValid, ucDataValid, cohDataValid}), 64'd0);
      @(posedge clock);
      #1;

      // Normal traffic resumes after the reset
      applyStimulus(4'd2, 3'd3, 40'h800, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("drain_uc_hdr", 64'(ucHdrQ.size()), 64'd0);
      checkOutput("drain_coh_hdr", 64'(cohHdrQ.size()), 64'd0);
      checkOutput("drain_uc_beat", 64'(ucBeatQ.size()), 64'd0);
      checkOutput("drain_coh_beat", 64'(cohBeatQ.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
